// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts instruction words, reads the register file,
// drives the ALU enable/rdy handshake and writes results back.
module alu_issue_ctrl #(
  parameter int NREGS   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        alu_enable,
  output logic [5:0]  alu_func,
  output logic [31:0] alu_x1,
  output logic [31:0] alu_x2,
  output logic [15:0] alu_imm,
  input  logic [31:0] alu_y,
  input  logic        alu_rdy,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [2:0]  dbg_sel,
  output logic [31:0] dbg_data
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ARM, EXEC, WB, ABORT
  } state_t;

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            en_q, en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [5:0]      func_q, func_d;
  logic [31:0]     x1_q, x1_d;
  logic [31:0]     x2_q, x2_d;
  logic [15:0]     imm_q, imm_d;
  logic [2:0]      rd_q, rd_d;
  logic [31:0]     y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     regs_q [8];
  logic [31:0]     regs_d [8];
  logic [31:0]     rs1_val, rs2_val;
  logic            unused_ok;

  // Index 0 and indices beyond NREGS read as zero and swallow writes.
  function automatic logic rd_ok(input logic [2:0] i);
    return (i != 3'd0) && (32'(i) < NREGS);
  endfunction

  assign rs1_val   = rd_ok(instr[22:20]) ? regs_q[instr[22:20]] : '0;
  assign rs2_val   = rd_ok(instr[19:17]) ? regs_q[instr[19:17]] : '0;
  assign dbg_data  = rd_ok(dbg_sel) ? regs_q[dbg_sel] : '0;
  assign unused_ok = instr[16];

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    func_d  = func_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid && ready_q) begin
          func_d  = instr[31:26];
          rd_d    = instr[25:23];
          x1_d    = rs1_val;
          x2_d    = rs2_val;
          imm_d   = instr[15:0];
          state_d = ARM;
        end
      end
      ARM: begin
        // A stale rdy from the previous op must clear first.
        if (!alu_rdy) begin
          state_d = EXEC;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      EXEC: begin
        if (alu_rdy) begin
          y_d     = alu_y;
          done_d  = 1'b1;
          state_d = WB;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
          en_d  = 1'b1;
        end
      end
      WB: begin
        if (rd_ok(rd_q)) regs_d[rd_q] = y_q;
        state_d = IDLE;
      end
      ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      func_q  <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      func_q  <= func_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign alu_enable  = en_q;
  assign done        = done_q;
  assign err         = err_q;
  assign alu_func    = func_q;
  assign alu_x1      = x1_q;
  assign alu_x2      = x2_q;
  assign alu_imm     = imm_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU enable/rdy handshake.
- Accepts 32-bit instruction words over a valid/ready interface and reads operands from an internal register file.
- Presents func/x1/x2/imm to the ALU, raises alu_enable, waits for alu_rdy, then writes the result back to the destination register.
- Sits between instruction decode and the ALU. It is the only driver of the ALU inputs.

Parameters:
- NREGS, 8, number of 32-bit registers. Must be a power of two, maximum 8; index width is 3.
- TIMEOUT, 16, EXEC cycles allowed without alu_rdy before the operation is aborted.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- instr_valid  input  1  instruction word present
- instr  input  32  [31:26] func, [25:23] rd, [22:20] rs1, [19:17] rs2, [15:0] imm
- instr_ready  output  1  controller can accept an instruction
- alu_enable  output  1  ALU start; the ALU acts on its rising edge
- alu_func  output  6  function code, passed through unmodified
- alu_x1  output  32  operand 1 = reg[rs1]
- alu_x2  output  32  operand 2 = reg[rs2]
- alu_imm  output  16  instr[15:0]
- alu_y  input  32  ALU result
- alu_rdy  input  1  ALU result valid
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on writeback
- err  output  1  one-cycle pulse on timeout abort
- dbg_sel  input  3  register-file debug read index
- dbg_data  output  32  reg[dbg_sel], combinational

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all registers cleared to 0.
  - alu_enable, alu_func, alu_x1, alu_x2, alu_imm, done, err, busy all 0; instr_ready 0 while in reset.
- Register 0:
  - reads always return 0.
  - writes to register 0 are discarded, but done still pulses.
- States:
  - IDLE: instr_ready=1.
    - If instr_valid, latch func/rd/rs1/rs2/imm and go to ARM.
    - Otherwise stay.
  - ARM: instr_ready=0, alu_enable=0.
    - Drive alu_func/alu_imm from the latch, alu_x1=reg[rs1], alu_x2=reg[rs2] (registered).
    - If alu_rdy=0, go to EXEC.
    - If alu_rdy is still 1 (stale from a previous op), stay in ARM. Operands stay stable.
  - EXEC: alu_enable=1; operands held constant; counter increments each cycle.
    - If alu_rdy=1 is sampled, capture alu_y and go to WB.
    - If the counter reaches TIMEOUT with no rdy, go to ABORT.
  - WB: alu_enable=0; write captured y to reg[rd]; done=1 for this cycle; next state IDLE.
  - ABORT: alu_enable=0; err=1 for this cycle; no register write; next state IDLE.
- Minimum latency with alu_rdy returned on the first EXEC cycle:
  - accept at edge T0
  - ARM T1
  - EXEC T2
  - WB T3 (done high)
  - IDLE T4
  - Throughput: one instruction per 4 cycles.
- alu_enable:
  - Always returns to 0 for at least one cycle between operations, so every op produces a fresh rising edge.
  - Never asserted outside EXEC.
- Writeback takes effect at the end of WB, so an immediately following instruction that reads rd sees the new value in ARM. No hazard logic is required.
- The controller does not interpret func. Unknown codes produce no alu_rdy and are handled by TIMEOUT.
- Reset mid-operation, from any state:
  - immediate return to IDLE.
  - alu_enable drops asynchronously.
  - registers cleared.
  - no done or err pulse.
- instr_valid while busy is ignored. instr_ready is low, so no instruction is lost or double-accepted.
- done and err are never high in the same cycle.

Test Plan:
- Reset check: hold rst=0, then release.
  - -> all outputs 0 during reset.
  - -> instr_ready=1 on the first cycle after release.
  - -> dbg_data=0 for every dbg_sel.
- MV writeback: MV rd=1 imm=0x1234 with a behavioural ALU answering rdy in 1 cycle.
  - -> alu_imm=0x1234 while enable is high.
  - -> done pulses exactly 3 cycles after acceptance.
  - -> reg[1]=0x00001234.
- Back-to-back operands: MV r1=5, MV r2=7, then ADD rd=3 rs1=1 rs2=2, with instr_valid held high throughout.
  - -> alu_x1=5, alu_x2=7 on the third op.
  - -> reg[3]=12.
  - -> alu_enable has a low gap between all three ops.
- Register 0 discard: ADD rd=0 with result 0xFFFF_FFFF.
  - -> done pulses.
  - -> dbg_data for index 0 stays 0.
- Timeout: undefined func with the ALU never asserting rdy.
  - -> err pulses after TIMEOUT=16 EXEC cycles.
  - -> no register changes.
  - -> alu_enable=0.
  - -> back in IDLE.
- Reset mid-EXEC, plus stale rdy:
  - assert rst=0 during EXEC -> alu_enable drops immediately; no done or err.
  - separately, hold alu_rdy=1 into a new op -> controller stays in ARM until rdy=0.
